mul_pipe_cell: RTL and testbench



---
 rtl/mul_pkg.sv | 20 ++
 rtl/mul_pp_cell.sv | 25 ++
 rtl/mul_pipe_cell.sv | 111 +++++++++++
 tb/tb_mul_pipe_cell.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the pipelined multiplier: op codes and signedness decode.
package mul_pkg;

  localparam int OPW = 2;

  localparam logic [OPW-1:0] MUL_OP_MUL = 2'd0;
  localparam logic [OPW-1:0] MUL_OP_XSS = 2'd1;
  localparam logic [OPW-1:0] MUL_OP_XUU = 2'd2;
  localparam logic [OPW-1:0] MUL_OP_XSU = 2'd3;

  // The first letter of the mnemonic gives src1 signedness, the second gives src2.
  function automatic logic op_a_signed(input logic [OPW-1:0] op);
    return (op == MUL_OP_XSS) || (op == MUL_OP_XSU);
  endfunction

  function automatic logic op_b_signed(input logic [OPW-1:0] op);
    return (op == MUL_OP_XSS);
  endfunction

endpackage

// File: rtl/mul_pp_cell.sv
// Registered unsigned HxH multiplier. Written as a plain multiply so that it maps onto a DSP block.
module mul_pp_cell #(
  parameter int H = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           en,
  input  logic [H-1:0]   i_a,
  input  logic [H-1:0]   i_b,
  output logic [2*H-1:0] o_prod
);

  logic [2*H-1:0] r_prod;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prod <= '0;
    end else if (en) begin
      r_prod <= {{H{1'b0}}, i_a} * {{H{1'b0}}, i_b};
    end
  end

  assign o_prod = r_prod;

endmodule

// File: rtl/mul_pipe_cell.sv
// Pipelined WIDTH x WIDTH multiplier returning the low word (MUL) or a signed/unsigned high word.
// Defining MUL_PIPE_CELL_OUT_REG_EN adds an output register stage, which raises the latency from 2 to 3.
module mul_pipe_cell
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             in_valid,
  input  logic [OPW-1:0]   in_op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_result
);

  localparam int H  = WIDTH / 2;
  localparam int W2 = 2 * WIDTH;

  logic [WIDTH-1:0] w_pp_ll, w_pp_lh, w_pp_hl, w_pp_hh;

  mul_pp_cell #(.H(H)) u_pp_ll (.clk(clk), .reset_n(reset_n), .en(en),
    .i_a(src1[H-1:0]),     .i_b(src2[H-1:0]),     .o_prod(w_pp_ll));
  mul_pp_cell #(.H(H)) u_pp_lh (.clk(clk), .reset_n(reset_n), .en(en),
    .i_a(src1[H-1:0]),     .i_b(src2[WIDTH-1:H]), .o_prod(w_pp_lh));
  mul_pp_cell #(.H(H)) u_pp_hl (.clk(clk), .reset_n(reset_n), .en(en),
    .i_a(src1[WIDTH-1:H]), .i_b(src2[H-1:0]),     .o_prod(w_pp_hl));
  mul_pp_cell #(.H(H)) u_pp_hh (.clk(clk), .reset_n(reset_n), .en(en),
    .i_a(src1[WIDTH-1:H]), .i_b(src2[WIDTH-1:H]), .o_prod(w_pp_hh));

  logic             r_s1_valid;
  logic [OPW-1:0]   r_s1_op;
  logic             r_s1_a_neg;
  logic             r_s1_b_neg;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= '0;
      r_s1_a_neg <= 1'b0;
      r_s1_b_neg <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else if (en) begin
      r_s1_valid <= in_valid;
      r_s1_op    <= in_op;
      r_s1_a_neg <= op_a_signed(in_op) & src1[WIDTH-1];
      r_s1_b_neg <= op_b_signed(in_op) & src2[WIDTH-1];
      r_s1_a     <= src1;
      r_s1_b     <= src2;
    end
  end

  // A negative signed operand reads as X + 2^W in the unsigned product,
  // so the other operand is subtracted once from the high word to correct it.
  logic [W2-1:0]    w_p;
  logic [WIDTH-1:0] w_corr_a;
  logic [WIDTH-1:0] w_corr_b;
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_s2_result;

  always_comb begin
    w_p = {{WIDTH{1'b0}}, w_pp_ll}
        + ({{WIDTH{1'b0}}, w_pp_lh} << H)
        + ({{WIDTH{1'b0}}, w_pp_hl} << H)
        + ({{WIDTH{1'b0}}, w_pp_hh} << WIDTH);
    w_corr_a    = r_s1_a_neg ? r_s1_b : '0;
    w_corr_b    = r_s1_b_neg ? r_s1_a : '0;
    w_hi        = w_p[W2-1:WIDTH] - w_corr_a - w_corr_b;
    w_s2_result = (r_s1_op == MUL_OP_MUL) ? w_p[WIDTH-1:0] : w_hi;
  end

  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_result;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
    end else if (en) begin
      r_s2_valid  <= r_s1_valid;
      r_s2_result <= w_s2_result;
    end
  end

`ifdef MUL_PIPE_CELL_OUT_REG_EN
  logic             r_s3_valid;
  logic [WIDTH-1:0] r_s3_result;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s3_valid  <= 1'b0;
      r_s3_result <= '0;
    end else if (en) begin
      r_s3_valid  <= r_s2_valid;
      r_s3_result <= r_s2_result;
    end
  end

  assign out_valid  = r_s3_valid;
  assign out_result = r_s3_result;
`else
  assign out_valid  = r_s2_valid;
  assign out_result = r_s2_result;
`endif

endmodule

// File: tb/tb_mul_pipe_cell.sv
// Bench for mul_pipe_cell at WIDTH=32: a vector table, hand-written stall/bubble/reset sequences and a random sweep.
// The expected latency follows MUL_PIPE_CELL_OUT_REG_EN in the same way the design does.
module tb_mul_pipe_cell;

`ifdef MUL_PIPE_CELL_OUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk;
  logic        reset_n;
  logic        en;
  logic        in_valid;
  logic [1:0]  in_op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        out_valid;
  logic [31:0] out_result;

  mul_pipe_cell #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .in_valid(in_valid), .in_op(in_op),
    .src1(src1), .src2(src2), .out_valid(out_valid), .out_result(out_result)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard entry: {valid, result}, one per enabled edge
  logic [32:0] exp_q[$];
  logic [32:0] cur;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[10];

  // Reference: sign- or zero-extend to 64 bits, multiply, then pick a word
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    sa = (op == 2'd1 || op == 2'd3) ? longint'($signed(a)) : longint'({32'b0, a});
    sb = (op == 2'd1) ? longint'($signed(b)) : longint'({32'b0, b});
    p  = 64'(sa * sb);
    return (op == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < LAT - 1; i++) exp_q.push_back(33'd0);
    cur = 33'd0;
  endtask

  // Driver: apply one cycle of inputs, advance one edge, then check against the scoreboard
  task automatic step(input logic e, input logic v, input logic [1:0] op,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] er);
    en = e; in_valid = v; in_op = op; src1 = a; src2 = b;
    @(posedge clk);
    #1;
    if (e) begin
      exp_q.push_back({v, er});
      cur = exp_q.pop_front();
    end
    check("out_valid", {31'd0, out_valid}, {31'd0, cur[32]});
    if (cur[32]) check("out_result", out_result, cur[31:0]);
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    step(1'b1, 1'b1, op, a, b, ref_mul(op, a, b));
  endtask

  task automatic bubble();
    step(1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0);
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] corners[5];
    corners[0] = 32'h0000_0000; corners[1] = 32'h0000_0001; corners[2] = 32'h7FFF_FFFF;
    corners[3] = 32'h8000_0000; corners[4] = 32'hFFFF_FFFF;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    tbl[0] = '{2'd0, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F};
    tbl[1] = '{2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    tbl[2] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    tbl[3] = '{2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    tbl[4] = '{2'd0, 32'd7,         32'd6,         32'd42};
    tbl[5] = '{2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    tbl[6] = '{2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    tbl[7] = '{2'd2, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001};
    tbl[8] = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    tbl[9] = '{2'd1, 32'hFFFF_FFFF, 32'h0000_0005, 32'hFFFF_FFFF};

    // Reset state: held through enabled edges, outputs stay cleared
    reset_n = 1'b0; en = 1'b1; in_valid = 1'b1; in_op = 2'd0;
    src1 = 32'd3; src2 = 32'd5;
    #1;
    check("reset_valid", {31'd0, out_valid}, 32'd0);
    check("reset_result", out_result, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_en_valid", {31'd0, out_valid}, 32'd0);
    check("reset_en_result", out_result, 32'd0);
    #3 reset_n = 1'b1;
    model_reset();

    // Vector table issued back-to-back, then drained
    for (int i = 0; i < 10; i++)
      step(1'b1, 1'b1, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp);
    repeat (LAT) bubble();

    // Stall: 42 must stay behind the freeze and appear after exactly LAT enabled edges
    issue(2'd2, 32'hDEAD_BEEF, 32'h1234_5678);
    issue(2'd0, 32'd7, 32'd6);
    repeat (3) step(1'b0, 1'b1, 2'd1, 32'hFFFF_FFFF, 32'd9, 32'd0);
    repeat (LAT) bubble();

    // Bubble pattern 1,0,1
    issue(2'd0, 32'd11, 32'd13);
    bubble();
    issue(2'd3, 32'hFFFF_FFF0, 32'd100);
    repeat (LAT) bubble();

    // Reset with ops in flight: outputs clear at once, nothing stale afterwards
    issue(2'd0, 32'd100, 32'd200);
    issue(2'd1, 32'h8000_0001, 32'd3);
    issue(2'd2, 32'hFFFF_0000, 32'h0001_0000);
    reset_n = 1'b0;
    #1;
    check("midreset_valid", {31'd0, out_valid}, 32'd0);
    check("midreset_result", out_result, 32'd0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    model_reset();
    repeat (LAT + 1) bubble();
    issue(2'd0, 32'd9, 32'd9);
    repeat (LAT) bubble();

    // Random sweep with occasional stalls and bubbles
    for (int i = 0; i < 10000; i++) begin
      logic        e, v;
      logic [1:0]  op;
      logic [31:0] a, b;
      e  = ($urandom_range(0, 7) != 0);
      v  = ($urandom_range(0, 5) != 0);
      op = 2'($urandom_range(0, 3));
      a  = rand_operand();
      b  = rand_operand();
      step(e, v, op, a, b, ref_mul(op, a, b));
    end
    repeat (LAT) bubble();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
